// File: rtl/acumulador_saturador.sv
// rtl/acumulador_saturador.sv - guarded MAC accumulator with Q(2F)->Q(F) rescale and saturation
// Optional build macro: ACC_ROUNDING_EN (round half toward +inf before the rescale shift).
module acumulador_saturador #(
  parameter int N    = 16,
  parameter int FRAC = 8,
  parameter int TAPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             prod_valid,
  input  logic [2*(N-1):0] prod,
  output logic [N-1:0]     y,
  output logic             y_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int P_W   = 2*N - 1;
  localparam int ACC_W = P_W + $clog2(TAPS) + 1;
  localparam int CNT_W = $clog2(TAPS);

  localparam logic [CNT_W-1:0]        LAST  = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2**(N-1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                   state, state_next;
  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  cnt;
  logic                     acc_clr, acc_add;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_round;
  logic signed [ACC_W-1:0]  scaled;
  logic        [N-1:0]      y_sat;
  logic                     ovf_sat;

  always_comb begin
    state_next = state;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_clr    = 1'b1;
          state_next = ACC;
        end
      end
      ACC: begin
        if (prod_valid) begin
          acc_add = 1'b1;
          if (cnt == LAST) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};

`ifdef ACC_ROUNDING_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);
  assign acc_round = acc + HALF;
`else
  assign acc_round = acc;
`endif

  assign scaled = acc_round >>> FRAC;

  always_comb begin
    y_sat   = scaled[N-1:0];
    ovf_sat = 1'b0;
    if (scaled > Y_MAX) begin
      y_sat   = Y_MAX[N-1:0];
      ovf_sat = 1'b1;
    end else if (scaled < Y_MIN) begin
      y_sat   = Y_MIN[N-1:0];
      ovf_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      ovf     <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      state   <= state_next;
      y_valid <= (state == DONE);
      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_add) begin
        acc <= acc + prod_ext;
        cnt <= cnt + 1'b1;
      end
      // Output registers only move on the DONE cycle; they hold otherwise.
      if (state == DONE) begin
        y   <= y_sat;
        ovf <= ovf_sat;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
